nand_tree_response_checker: RTL and testbench
=============================================

// Module: nand_tree_response_checker
// PURPOSE
//  Response end of the 4-input NAND-tree exhaustive test: consumes each applied input vector
//  and the DUT outputs, compares them to the golden NAND-tree model, and counts mismatches.
//  Vector coverage is tracked in a 16-entry bitmap, so the block reports pass/fail only after
//  every 4-bit vector has been checked at least once. Sits beside the DUT on the board or in the bench.
// PARAMETERS
//  SETTLE_CYCLES  2   clk cycles between vector acceptance and output sampling (1..15)
//  ERR_W          5   width of err_count; the counter saturates at 2**ERR_W-1
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      asynchronous, active-high reset
//  start           in   1      1-cycle pulse: clear results and arm the checker
//  vec_valid       in   1      vec_in holds a newly applied vector this cycle
//  vec_in          in   4      applied vector {a,b,c,d}
//  obs_in          in   3      DUT outputs {e,f,g}
//  busy            out  1      armed and not yet done
//  done            out  1      all 16 vectors checked; stays high until start or reset
//  pass            out  1      done && err_count==0
//  err_count       out  ERR_W  count of mismatching checks, saturating
//  first_fail_vld  out  1      a first failure has been captured
//  first_fail_vec  out  4      vector of the first mismatch
//  first_fail_obs  out  3      observed {e,f,g} of the first mismatch
// BEHAVIOUR
//  Golden model: e=~(a&b), f=~(c&d), g=~(~e&~f) (equivalent to ~(a&b&c&d)).
//  Reset (async, active-high): state=IDLE. busy, done, pass, err_count, first_fail_* = 0.
//    Coverage bitmap = 0. Reset mid-run aborts the run immediately; no result is kept.
//  States:
//    IDLE   - start -> ARMED; clear err_count, bitmap, first_fail_*, done, pass.
//    ARMED  - vec_valid -> SETTLE; latch vec_in into vec_q; load settle_cnt=SETTLE_CYCLES-1.
//    SETTLE - decrement settle_cnt; at 0 -> CHECK. vec_valid here is ignored (not latched).
//    CHECK  - single cycle: compare obs_in to golden(vec_q) and set bitmap[vec_q].
//             mismatch: err_count+1 (saturates); if !first_fail_vld, capture vec_q and obs_in
//             and set first_fail_vld. Next state: DONE if bitmap incl. this bit == 16'hFFFF,
//             else ARMED.
//    DONE   - done=1, pass=(err_count==0). start -> clear everything, go to ARMED.
//  busy = 1 in ARMED, SETTLE and CHECK; 0 in IDLE and DONE.
//  start in ARMED, SETTLE or CHECK restarts the run: clear all results and go to ARMED;
//    the in-flight vector is discarded.
//  Repeated vectors are checked and counted again; they do not advance coverage.
//  Latency: obs_in is sampled SETTLE_CYCLES+1 clk edges after the vec_valid edge.
//    Sampling happens in CHECK, one cycle after settle_cnt reaches 0.
//  done/pass are registered and rise the cycle after the CHECK that completes coverage.
//  obs_in containing X/Z counts as a mismatch (case-equality compare in simulation).
// TESTING
//  1 reset, start, 16 vectors 0..15 with correct obs -> done=1, pass=1, err_count=0 after last CHECK.
//  2 vector 4'hF with obs=3'b000 (golden 3'b000); vector 4'hC with obs=3'b011 (golden 3'b011)
//    -> no errors; vector 4'h0 with obs=3'b110 -> err_count=1, first_fail_vec=0, first_fail_obs=3'b110.
//  3 15 distinct vectors, then vector 3 repeated 40 times with wrong obs
//    -> done stays 0, err_count saturates at 31; then vector 15 -> done=1, pass=0.
//  4 vec_valid pulsed during SETTLE with another vector -> ignored; only the first vector is
//    checked, and sampling occurs exactly SETTLE_CYCLES+1 edges after the first vec_valid.
//  5 assert reset mid-SETTLE (asynchronous, between edges) -> all outputs 0 immediately;
//    a later start followed by the full sweep -> pass=1.
//  6 in DONE, pulse start -> done=0, err_count=0, first_fail_vld=0, busy=1 on the next cycle.

Source files
------------

// File: rtl/nand_tree_response_checker_if.sv
// Handshake and result bundle for the NAND-tree response checker.
//   start, vec_valid, vec_in[3:0], obs_in[2:0]        : stimulus side (master drives)
//   busy, done, pass, err_count, first_fail_{vld,vec,obs} : results (checker drives)
interface nand_tree_response_checker_if #(
    parameter int unsigned ERR_W = 5
);
    logic             start;
    logic             vec_valid;
    logic [3:0]       vec_in;
    logic [2:0]       obs_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_vld;
    logic [3:0]       first_fail_vec;
    logic [2:0]       first_fail_obs;

    modport master (
        output start, vec_valid, vec_in, obs_in,
        input  busy, done, pass, err_count, first_fail_vld, first_fail_vec, first_fail_obs
    );

    modport slave (
        input  start, vec_valid, vec_in, obs_in,
        output busy, done, pass, err_count, first_fail_vld, first_fail_vec, first_fail_obs
    );
endinterface

// File: rtl/nand_tree_response_checker.sv
// Response checker for the 4-input NAND-tree exhaustive test. Each accepted
// vector is held for SETTLE_CYCLES, then the DUT outputs are compared with the
// golden model. Mismatches are counted (saturating) and the first one captured.
// Pass/fail is reported once all 16 vectors have been covered.
//   clk, reset : clock, asynchronous active-high reset
//   chk_if     : slave side of nand_tree_response_checker_if
module nand_tree_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    nand_tree_response_checker_if.slave   chk_if
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [15:0]      bitmap_q, bitmap_d;
    logic             ff_vld_q, ff_vld_d;
    logic [3:0]       ff_vec_q, ff_vec_d;
    logic [2:0]       ff_obs_q, ff_obs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       golden_c;
    logic             mismatch_c;

    // Golden NAND tree: e=~(a&b), f=~(c&d), g=~(~e&~f), vector is {a,b,c,d}
    always_comb begin
        golden_c[2] = ~(vec_q[3] & vec_q[2]);
        golden_c[1] = ~(vec_q[1] & vec_q[0]);
        golden_c[0] = ~(~golden_c[2] & ~golden_c[1]);
        // Case inequality so X/Z on the observed outputs is a mismatch
        mismatch_c  = (chk_if.obs_in !== golden_c);
    end

    // Next-state and result update
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        err_count_d  = err_count_q;
        bitmap_d     = bitmap_q;
        ff_vld_d     = ff_vld_q;
        ff_vec_d     = ff_vec_q;
        ff_obs_d     = ff_obs_q;

        if (chk_if.start) begin
            // start from any state clears results and discards an in-flight vector
            state_d     = ARMED;
            err_count_d = '0;
            bitmap_d    = '0;
            ff_vld_d    = 1'b0;
            ff_vec_d    = '0;
            ff_obs_d    = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (chk_if.vec_valid) begin
                        vec_d        = chk_if.vec_in;
                        settle_cnt_d = CNT_W'(SETTLE_CYCLES - 1);
                        state_d      = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_d = CHECK;
                    end else begin
                        settle_cnt_d = settle_cnt_q - CNT_W'(1);
                    end
                end
                CHECK: begin
                    bitmap_d = bitmap_q | (16'(1) << vec_q);
                    if (mismatch_c) begin
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (!ff_vld_q) begin
                            ff_vld_d = 1'b1;
                            ff_vec_d = vec_q;
                            ff_obs_d = chk_if.obs_in;
                        end
                    end
                    state_d = (bitmap_d == 16'hFFFF) ? DONE : ARMED;
                end
                default: ;
            endcase
        end

        // Status flags are registered from the next state so they track it exactly
        busy_d = (state_d == ARMED) || (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_count_d == '0);
    end

    // State and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_cnt_q <= '0;
            err_count_q  <= '0;
            bitmap_q     <= '0;
            ff_vld_q     <= 1'b0;
            ff_vec_q     <= '0;
            ff_obs_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            err_count_q  <= err_count_d;
            bitmap_q     <= bitmap_d;
            ff_vld_q     <= ff_vld_d;
            ff_vec_q     <= ff_vec_d;
            ff_obs_q     <= ff_obs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign chk_if.busy           = busy_q;
    assign chk_if.done           = done_q;
    assign chk_if.pass           = pass_q;
    assign chk_if.err_count      = err_count_q;
    assign chk_if.first_fail_vld = ff_vld_q;
    assign chk_if.first_fail_vec = ff_vec_q;
    assign chk_if.first_fail_obs = ff_obs_q;
endmodule

// File: tb/tb_nand_tree_response_checker.sv
// Self-checking bench for nand_tree_response_checker. Expected results are
// pushed to a scoreboard queue as each vector is driven and popped once the
// checker has sampled that vector.
module tb_nand_tree_response_checker;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned EW     = 5;

    typedef struct {
        logic [EW-1:0] err;
        logic          ff_vld;
        logic [3:0]    ff_vec;
        logic [2:0]    ff_obs;
        logic          done;
        logic          pass;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    exp_t          sb_q[$];
    logic [EW-1:0] m_err;
    logic          m_ff_vld;
    logic [3:0]    m_ff_vec;
    logic [2:0]    m_ff_obs;
    logic [15:0]   m_bitmap;

    nand_tree_response_checker_if #(.ERR_W(EW)) cif ();

    nand_tree_response_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(EW)) dut (
        .clk    (clk),
        .reset  (reset),
        .chk_if (cif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference outputs {e,f,g}; g written in its collapsed 4-input form
    function automatic logic [2:0] ref_out(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {~(a & b), ~(c & d), ~(a & b & c & d)};
    endfunction

    task automatic model_clear();
        m_err    = '0;
        m_ff_vld = 1'b0;
        m_ff_vec = '0;
        m_ff_obs = '0;
        m_bitmap = '0;
        sb_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(cif.busy), 0);
        check_eq({tag, "_done"}, 32'(cif.done), 0);
        check_eq({tag, "_pass"}, 32'(cif.pass), 0);
        check_eq({tag, "_err"},  32'(cif.err_count), 0);
        check_eq({tag, "_ffv"},  32'(cif.first_fail_vld), 0);
        check_eq({tag, "_ffvec"}, 32'(cif.first_fail_vec), 0);
        check_eq({tag, "_ffobs"}, 32'(cif.first_fail_obs), 0);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        cif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cif.start = 1'b0;
        model_clear();
        check_eq({tag, "_busy"}, 32'(cif.busy), 1);
        check_eq({tag, "_done"}, 32'(cif.done), 0);
        check_eq({tag, "_err"},  32'(cif.err_count), 0);
        check_eq({tag, "_ffv"},  32'(cif.first_fail_vld), 0);
    endtask

    // Drive one vector with observed outputs obs. With glitch set, a different
    // vector is offered during SETTLE and obs_in is wrong on every edge except
    // the one SETTLE+1 edges after acceptance.
    task automatic send_vec(input string tag, input logic [3:0] v, input logic [2:0] obs,
                            input bit glitch);
        exp_t e;
        exp_t got;
        @(negedge clk);
        cif.vec_valid = 1'b1;
        cif.vec_in    = v;
        cif.obs_in    = glitch ? ~obs : obs;
        if (obs !== ref_out(v)) begin
            if (m_err != '1) m_err = m_err + 1'b1;
            if (!m_ff_vld) begin
                m_ff_vld = 1'b1;
                m_ff_vec = v;
                m_ff_obs = obs;
            end
        end
        m_bitmap[v] = 1'b1;
        e.err    = m_err;
        e.ff_vld = m_ff_vld;
        e.ff_vec = m_ff_vec;
        e.ff_obs = m_ff_obs;
        e.done   = (m_bitmap == 16'hFFFF);
        e.pass   = e.done && (m_err == '0);
        sb_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        cif.vec_valid = 1'b0;
        if (glitch) begin
            cif.vec_valid = 1'b1;
            cif.vec_in    = ~v;
        end
        for (int i = 1; i <= int'(SETTLE); i++) begin
            @(posedge clk);
            @(negedge clk);
            cif.vec_valid = 1'b0;
            if (glitch && i == int'(SETTLE)) cif.obs_in = obs;
        end
        @(posedge clk);
        @(negedge clk);
        if (glitch) cif.obs_in = ~obs;

        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
        end else begin
            got = sb_q.pop_front();
            check_eq({tag, "_err"},   32'(cif.err_count),      32'(got.err));
            check_eq({tag, "_ffv"},   32'(cif.first_fail_vld), 32'(got.ff_vld));
            check_eq({tag, "_ffvec"}, 32'(cif.first_fail_vec), 32'(got.ff_vec));
            check_eq({tag, "_ffobs"}, 32'(cif.first_fail_obs), 32'(got.ff_obs));
            check_eq({tag, "_done"},  32'(cif.done),           32'(got.done));
            check_eq({tag, "_pass"},  32'(cif.pass),           32'(got.pass));
            check_eq({tag, "_busy"},  32'(cif.busy),           32'(!got.done));
        end
    endtask

    task automatic sweep(input string tag, input bit glitch);
        for (int v = 0; v < 16; v++) send_vec(tag, 4'(v), ref_out(4'(v)), glitch);
    endtask

    initial begin
        cif.start     = 1'b0;
        cif.vec_valid = 1'b0;
        cif.vec_in    = '0;
        cif.obs_in    = '0;
        model_clear();

        // 1: reset state, then a clean full sweep
        #12;
        check_idle_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        pulse_start("t1_start");
        sweep("t1", 1'b0);
        check_eq("t1_final_pass", 32'(cif.pass), 1);

        // 2: two correct vectors, then a wrong one captured as first failure
        pulse_start("t2_start");
        send_vec("t2_f", 4'hF, 3'b000, 1'b0);
        send_vec("t2_c", 4'hC, 3'b011, 1'b0);
        send_vec("t2_0", 4'h0, 3'b110, 1'b0);
        check_eq("t2_ffobs_lit", 32'(cif.first_fail_obs), 32'(3'b110));

        // 4: vec_valid during SETTLE ignored, sampling on exact edge
        pulse_start("t4_start");
        sweep("t4", 1'b1);
        check_eq("t4_final_pass", 32'(cif.pass), 1);

        // 3: repeats do not advance coverage; error count saturates
        pulse_start("t3_start");
        for (int v = 0; v < 15; v++) send_vec("t3_a", 4'(v), ref_out(4'(v)), 1'b0);
        for (int k = 0; k < 40; k++) send_vec("t3_rep", 4'h3, ~ref_out(4'h3), 1'b0);
        check_eq("t3_sat", 32'(cif.err_count), 31);
        check_eq("t3_notdone", 32'(cif.done), 0);
        send_vec("t3_last", 4'hF, ref_out(4'hF), 1'b0);
        check_eq("t3_done", 32'(cif.done), 1);
        check_eq("t3_fail", 32'(cif.pass), 0);

        // 6: start from DONE clears results on the next cycle
        pulse_start("t6");

        // 5: asynchronous reset mid-SETTLE, then a fresh sweep
        send_vec("t5_pre", 4'h0, 3'b000, 1'b0);
        @(negedge clk);
        cif.vec_valid = 1'b1;
        cif.vec_in    = 4'h5;
        cif.obs_in    = ref_out(4'h5);
        @(posedge clk);
        @(negedge clk);
        cif.vec_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_post");
        pulse_start("t5_start");
        sweep("t5", 1'b0);
        check_eq("t5_final_pass", 32'(cif.pass), 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
